// File: rtl/mul_iter.sv
// mul_iter -- iterative shift-add multiplier, responder side of the EX-stage
// start/ready multiply handshake. One multiplier bit is consumed per cycle;
// the 2*WIDTH-bit product is presented for exactly one cycle with ready_o.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (highest priority)
//   signed_mul_i   1 = signed multiply, 0 = unsigned; sampled with start
//   opdata1_i      multiplicand; sampled with start
//   opdata2_i      multiplier; sampled with start
//   start_i        request, held high by the initiator until ready_o
//   annul_i        abort the current operation
//   result_o       product, nonzero only while ready_o = 1
//   ready_o        one-cycle result-valid pulse
//
// Build option:
//   MUL_EARLY_TERM_EN  when defined, BUSY finishes as soon as the remaining
//                      multiplier bits are all zero instead of always
//                      running WIDTH iterations.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_mul_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] prod;
    logic               finish;
    logic               any_zero;

    // Magnitudes; the most negative value negates to itself, which is the
    // correct unsigned magnitude.
    assign abs1 = (signed_mul_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_mul_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign any_zero    = (opdata1_i == '0) || (opdata2_i == '0);
    assign acc_next    = acc + (mplier[0] ? mcand : '0);
    assign mplier_next = mplier >> 1;
    assign prod        = neg ? -acc_next : acc_next;

`ifdef MUL_EARLY_TERM_EN
    // No set bits left means no further additions can change the sum.
    assign finish = (cnt == LAST) || (mplier_next == '0);
`else
    assign finish = (cnt == LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    // annul wins over a simultaneous start
                    if (start_i && !annul_i) begin
                        mcand  <= {{WIDTH{1'b0}}, abs1};
                        mplier <= abs2;
                        neg    <= signed_mul_i &
                                  (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        if (any_zero) begin
                            // product is zero, skip the iterations
                            state   <= DONE;
                            ready_o <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (annul_i || !start_i) begin
                        // abandoned: nothing partial ever reaches result_o
                        state    <= IDLE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                        cnt    <= cnt + CW'(1);
                        if (finish) begin
                            state    <= DONE;
                            result_o <= prod;
                            ready_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // single-cycle pulse, start_i/annul_i don't matter here
                    state    <= IDLE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
                default: begin
                    state    <= IDLE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter -- self-checking bench for mul_iter. Expected products come
// from native 64-bit arithmetic and go through a scoreboard queue; latency
// is checked against the edge count from the first start-sampling edge.
module tb_mul_iter;

    logic        clk;
    logic        rst;
    logic        signed_mul;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];

    mul_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_mul_i (signed_mul),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (s) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int h;
        if (a == 0 || b == 0) return 1;
`ifdef MUL_EARLY_TERM_EN
        m = (s && b[31]) ? -b : b;
        h = 0;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        return h + 2;
`else
        m = 32'(s);
        h = 33;
        return h;
`endif
    endfunction

    // One full transaction; start is dropped in the DONE cycle.
    task automatic do_mul(input logic s, input logic [31:0] a, input logic [31:0] b, input string name);
        int lat;
        int edges;
        logic seen;
        logic leak;
        logic [63:0] exp;
        lat = exp_lat(s, a, b);
        sb_q.push_back(model(s, a, b));
        @(negedge clk);
        signed_mul = s; op1 = a; op2 = b; start = 1'b1;
        edges = 0; seen = 1'b0; leak = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                // operands may change once sampled
                op1 = $urandom; op2 = $urandom; signed_mul = ~s;
            end
            if (ready) seen = 1'b1;
            else if (result !== 64'd0) leak = 1'b1;
        end
        exp = sb_q.pop_front();
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no ready after %0d edges, required at edge %0d", name, edges, lat);
        end else begin
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL %s result: got %h required %h", name, result, exp);
            end
            if (edges !== lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, edges, lat);
            end
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL %s result_nonzero_while_not_ready: got 1 required 0", name);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL %s after_done: ready=%b result=%h required 0/0", name, ready, result);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_mul = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ready); end
        checks++;
        if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h required 0", result); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_unsigned;
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "unsigned_max");
        do_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "unsigned_mix");
    endtask

    task automatic test_signed;
        do_mul(1'b1, 32'hFFFF_FFFD, 32'd7, "signed_neg3x7");
        do_mul(1'b1, 32'd7, 32'hFFFF_FFFD, "signed_7xneg3");
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, "signed_minxmin");
        do_mul(1'b0, 32'h8000_0000, 32'h8000_0000, "unsigned_minxmin");
        do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "signed_neg1xneg1");
    endtask

    task automatic test_zero;
        do_mul(1'b0, 32'h1234_5678, 32'd0, "zero_op2_u");
        do_mul(1'b1, 32'h1234_5678, 32'd0, "zero_op2_s");
        do_mul(1'b1, 32'd0, 32'hFFFF_FFFF, "zero_op1_s");
    endtask

    task automatic test_annul;
        logic bad;
        bad = 1'b0;
        // simultaneous start + annul in IDLE: zero operand would finish at edge 1
        @(negedge clk);
        op1 = 32'd5; op2 = 32'd0; signed_mul = 1'b0; start = 1'b1; annul = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (ready) bad = 1'b1; end
        start = 1'b0; annul = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL idle_start_annul: ready seen, required none"); end
        // annul at edge 10 of a running multiply
        bad = 1'b0;
        @(negedge clk);
        op1 = 32'h0000_1234; op2 = 32'h0000_5678; start = 1'b1;
        for (int e = 1; e <= 9; e++) begin @(posedge clk); #1; if (ready) bad = 1'b1; end
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++; $display("FAIL annul_edge10: ready=%b result=%h required 0/0", ready, result);
        end
        repeat (40) begin @(posedge clk); #1; if (ready) bad = 1'b1; end
        checks++;
        if (bad) begin errors++; $display("FAIL annul_no_ready: ready seen, required none"); end
        do_mul(1'b0, 32'd6, 32'd7, "after_annul_6x7");
    endtask

    task automatic test_reset_mid;
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0003; signed_mul = 1'b0; start = 1'b1;
        for (int e = 1; e <= 19; e++) begin @(posedge clk); #1; if (ready) bad = 1'b1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++; $display("FAIL reset_mid: ready=%b result=%h required 0/0", ready, result);
        end
        rst = 1'b0; start = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready) bad = 1'b1; end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_mid_no_ready: ready seen, required none"); end
        do_mul(1'b1, 32'hFFFF_FF00, 32'h0000_0100, "after_reset");
    endtask

    task automatic test_back_to_back;
        do_mul(1'b0, 32'd1000, 32'd3000, "b2b_first");
        do_mul(1'b1, 32'hFFFF_F000, 32'd17, "b2b_second");
        // start held through DONE with a zero operand restarts immediately
        @(negedge clk);
        op1 = 32'd3; op2 = 32'd0; signed_mul = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL held_start_e1: ready=%b required 1", ready); end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL held_start_e2: ready=%b required 0", ready); end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL held_start_e3: ready=%b required 1", ready); end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early_term;
        do_mul(1'b0, 32'd5, 32'd1, "early_5x1");
        do_mul(1'b1, 32'd5, 32'hFFFF_FFFE, "early_5xneg2");
        do_mul(1'b0, 32'd9, 32'h0000_8000, "early_9xbit15");
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++)
            do_mul(1'($urandom), $urandom, $urandom, "random");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_early_term();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
